// File: rtl/bill_settle.sv
// rtl/bill_settle.sv - settlement stage: BCD charge, balance deduction, debt loop and display
module bill_settle #(
  parameter int SCAN_DIV = 100000,
  parameter int BUZZ_DIV = 25000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        m_pos_i,
  input  logic        u_pos_i,
  input  logic        d_pos_i,
  input  logic [1:0]  mode_i,
  input  logic [11:0] bal_in_i,
  input  logic [11:0] dy_price_i,
  input  logic [11:0] s_price_i,
  input  logic [11:0] m_price_i,
  input  logic [11:0] b_price_i,
  input  logic [11:0] fine_i,
  input  logic [3:0]  ot_units_i,
  output logic [11:0] charge_o,
  output logic [11:0] bal_out_o,
  output logic        next_o,
  output logic        buzzer_o,
  output logic [7:0]  led_o,
  output logic [3:0]  ena_o,
  output logic [7:0]  st_light_o,
  output logic [7:0]  wt_light_o
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BUZZ_DIV + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACC, S_CMP, S_PAID, S_DEBT
  } state_t;

  state_t         state_q;
  logic [11:0]    acc_q, work_q, base_q, fine_q, charge_q, bal_q;
  logic [3:0]     cnt_q;
  logic [SW-1:0]  scan_cnt_q;
  logic [1:0]     digit_q;
  logic [BW-1:0]  buzz_cnt_q;
  logic           buzzer_q;

  // Any digit above 9 is forced to 9 so downstream arithmetic only sees valid BCD.
  function automatic logic [11:0] bcd_clamp(input logic [11:0] v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  // Three-digit BCD add; a carry out of the hundreds digit saturates to 999.
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic        c;
    logic [4:0]  s;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return c ? 12'h999 : r;
  endfunction

  // Three-digit BCD subtract; caller guarantees a >= b.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic        bw;
    logic [4:0]  d;
    r  = '0;
    bw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, bw};
      if (d[4]) begin
        r[4*i +: 4] = 4'(d + 5'd10);
        bw = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        bw = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      default: return 8'h6F;
    endcase
  endfunction

  logic [11:0] price_d, acc_sum_d, work_up_d, work_dn_tmp, work_dn_d, work_adj_d;
  logic [3:0]  ot_clamp_d;

  // Next-value datapath: selected price, fine accumulation and debt-loop balance adjustment.
  always_comb begin
    case (mode_i)
      2'd0:    price_d = dy_price_i;
      2'd1:    price_d = s_price_i;
      2'd2:    price_d = m_price_i;
      default: price_d = b_price_i;
    endcase
    ot_clamp_d  = (ot_units_i > 4'd9) ? 4'd9 : ot_units_i;
    acc_sum_d   = bcd_add_sat(acc_q, fine_q);
    work_up_d   = bcd_add_sat(work_q, 12'h010);
    work_dn_tmp = bcd_sub(work_q, 12'h010);
    work_dn_d   = base_q;
    if (work_q >= 12'h010 && work_dn_tmp >= base_q)
      work_dn_d = work_dn_tmp;
    work_adj_d = work_q;
    if (u_pos_i && !d_pos_i)
      work_adj_d = work_up_d;
    else if (d_pos_i && !u_pos_i)
      work_adj_d = work_dn_d;
  end

  // Settlement FSM with its working registers, scan counter and buzzer generator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      work_q     <= '0;
      base_q     <= '0;
      fine_q     <= '0;
      charge_q   <= '0;
      bal_q      <= '0;
      cnt_q      <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      buzz_cnt_q <= '0;
      buzzer_q   <= 1'b0;
    end else if (!en_i) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      work_q     <= '0;
      base_q     <= '0;
      fine_q     <= '0;
      charge_q   <= '0;
      bal_q      <= '0;
      cnt_q      <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      buzz_cnt_q <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      // Digit scan free-runs while enabled; LOAD overrides it below to restart at digit 3.
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        digit_q    <= digit_q - 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: state_q <= S_LOAD;
        S_LOAD: begin
          acc_q      <= bcd_clamp(price_d);
          fine_q     <= bcd_clamp(fine_i);
          work_q     <= bcd_clamp(bal_in_i);
          base_q     <= bcd_clamp(bal_in_i);
          cnt_q      <= ot_clamp_d;
          scan_cnt_q <= '0;
          digit_q    <= 2'd3;
          // With no overtime there is nothing to add, so the ACC cycle is skipped.
          state_q    <= (ot_clamp_d == 4'd0) ? S_CMP : S_ACC;
        end
        S_ACC: begin
          if (cnt_q != 4'd0) begin
            acc_q <= acc_sum_d;
            cnt_q <= cnt_q - 4'd1;
          end
          if (cnt_q <= 4'd1)
            state_q <= S_CMP;
        end
        S_CMP: begin
          charge_q <= acc_q;
          if (work_q >= acc_q) begin
            bal_q   <= bcd_sub(work_q, acc_q);
            state_q <= S_PAID;
          end else begin
            bal_q   <= work_q;
            state_q <= S_DEBT;
          end
        end
        S_PAID: state_q <= S_PAID;
        S_DEBT: begin
          work_q <= work_adj_d;
          if (m_pos_i) begin
            state_q    <= S_CMP;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
          end else if (buzz_cnt_q == BUZZ_LAST) begin
            buzz_cnt_q <= '0;
            buzzer_q   <= ~buzzer_q;
          end else begin
            buzz_cnt_q <= buzz_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [11:0] disp_val;
  logic [7:0]  letter;
  logic [3:0]  wt_level;

  // Output decode from registered state: lights, water bar and the multiplexed display.
  always_comb begin
    charge_o   = charge_q;
    bal_out_o  = bal_q;
    buzzer_o   = buzzer_q;
    next_o     = en_i && (state_q == S_PAID);
    st_light_o = {4'd0, state_q == S_DEBT, state_q == S_PAID, state_q == S_CMP,
                  (state_q == S_LOAD) || (state_q == S_ACC)};
    wt_level   = (cnt_q > 4'd8) ? 4'd8 : cnt_q;
    wt_light_o = (state_q == S_ACC) ? 8'((16'd1 << wt_level) - 16'd1) : 8'd0;

    case (state_q)
      S_PAID: begin
        letter   = 8'h73;
        disp_val = bal_q;
      end
      S_DEBT: begin
        letter   = 8'h5E;
        disp_val = (work_q >= acc_q) ? 12'h000 : bcd_sub(acc_q, work_q);
      end
      default: begin
        letter   = 8'h40;
        disp_val = acc_q;
      end
    endcase

    if (state_q == S_IDLE) begin
      ena_o = 4'd0;
      led_o = 8'd0;
    end else begin
      ena_o = 4'b0001 << digit_q;
      case (digit_q)
        2'd3:    led_o = letter;
        2'd2:    led_o = seg7(disp_val[11:8]);
        2'd1:    led_o = seg7(disp_val[7:4]);
        default: led_o = seg7(disp_val[3:0]);
      endcase
    end
  end

endmodule

// File: tb/tb_bill_settle.sv
// tb/tb_bill_settle.sv - scoreboard bench for bill_settle
module tb_bill_settle;
  localparam int SCAN_DIV = 3;
  localparam int BUZZ_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en = 1'b0, m_pos = 1'b0, u_pos = 1'b0, d_pos = 1'b0;
  logic [1:0]  mode = '0;
  logic [11:0] bal_in = '0, dy_price = '0, s_price = '0, m_price = '0, b_price = '0, fine = '0;
  logic [3:0]  ot_units = '0;
  logic [11:0] charge_o, bal_out_o;
  logic        next_o, buzzer_o;
  logic [7:0]  led_o, st_light_o, wt_light_o;
  logic [3:0]  ena_o;

  typedef struct packed {
    logic [11:0] charge;
    logic [11:0] bal;
    logic        paid;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc;
  bit   ok;
  logic [31:0] disp;

  bill_settle #(.SCAN_DIV(SCAN_DIV), .BUZZ_DIV(BUZZ_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en),
    .m_pos_i(m_pos), .u_pos_i(u_pos), .d_pos_i(d_pos),
    .mode_i(mode), .bal_in_i(bal_in),
    .dy_price_i(dy_price), .s_price_i(s_price), .m_price_i(m_price), .b_price_i(b_price),
    .fine_i(fine), .ot_units_i(ot_units),
    .charge_o(charge_o), .bal_out_o(bal_out_o), .next_o(next_o), .buzzer_o(buzzer_o),
    .led_o(led_o), .ena_o(ena_o), .st_light_o(st_light_o), .wt_light_o(wt_light_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F; 4: return 8'h66;
      5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07; 8: return 8'h7F; default: return 8'h6F;
    endcase
  endfunction

  task automatic start(input logic [1:0] m, input logic [11:0] price, input logic [11:0] f,
                       input logic [3:0] o, input logic [11:0] b);
    dy_price = 12'h555; s_price = 12'h555; m_price = 12'h555; b_price = 12'h555;
    case (m)
      2'd0: dy_price = price;
      2'd1: s_price = price;
      2'd2: m_price = price;
      default: b_price = price;
    endcase
    mode = m; fine = f; ot_units = o; bal_in = b; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stop();
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_settle(output int c, output bit found);
    c = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (st_light_o[2] || st_light_o[3]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic get_digits(output logic [31:0] d, output bit found);
    logic [3:0] seen;
    seen = '0;
    d = '0;
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      case (ena_o)
        4'b1000: begin d[31:24] = led_o; seen[3] = 1'b1; end
        4'b0100: begin d[23:16] = led_o; seen[2] = 1'b1; end
        4'b0010: begin d[15:8]  = led_o; seen[1] = 1'b1; end
        4'b0001: begin d[7:0]   = led_o; seen[0] = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
    end
    found = (seen == 4'hF);
  endtask

  task automatic pulse(input bit u, input bit d, input bit m);
    u_pos = u; d_pos = d; m_pos = m;
    @(negedge clk);
    u_pos = 1'b0; d_pos = 1'b0; m_pos = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    n_checks++; if ({charge_o, bal_out_o, next_o, buzzer_o, led_o, ena_o, st_light_o, wt_light_o} !== '0)
      $display("FAIL reset_outputs got %h/%h st=%h ena=%h led=%h want all zero", charge_o, bal_out_o, st_light_o, ena_o, led_o); else n_pass++;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    n_checks++; if ({st_light_o, ena_o, next_o} !== '0)
      $display("FAIL idle_after_reset got st=%h ena=%h next=%b want 0", st_light_o, ena_o, next_o); else n_pass++;
  endtask

  task automatic test_simple_paid();
    sb.push_back({12'h045, 12'h055, 1'b1});
    start(2'd1, 12'h045, 12'h000, 4'd0, 12'h100);
    wait_settle(cyc, ok);
    n_checks++; if (!ok || cyc != 2) $display("FAIL simple_latency got %0d (found=%0d) want 2", cyc, ok); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (charge_o !== e.charge) $display("FAIL simple_charge got %h want %h", charge_o, e.charge); else n_pass++;
    n_checks++; if (bal_out_o !== e.bal) $display("FAIL simple_bal got %h want %h", bal_out_o, e.bal); else n_pass++;
    n_checks++; if (next_o !== e.paid || st_light_o !== 8'h04) $display("FAIL simple_next got next=%b st=%h want %b/04", next_o, st_light_o, e.paid); else n_pass++;
    get_digits(disp, ok);
    n_checks++; if (!ok || disp !== {8'h73, seg(0), seg(5), seg(5)})
      $display("FAIL simple_display got %h want %h", disp, {8'h73, seg(0), seg(5), seg(5)}); else n_pass++;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    n_checks++; if (bal_out_o !== 12'h055 || st_light_o !== 8'h04) $display("FAIL paid_ignores_buttons got %h st=%h want 055/04", bal_out_o, st_light_o); else n_pass++;
    en = 1'b0;
    #1;
    n_checks++; if (next_o !== 1'b0) $display("FAIL next_drop got %b want 0", next_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({charge_o, bal_out_o, next_o, led_o, ena_o, st_light_o} !== '0)
      $display("FAIL leave_paid got %h/%h st=%h ena=%h want 0", charge_o, bal_out_o, st_light_o, ena_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_overtime();
    sb.push_back({12'h173, 12'h027, 1'b1});
    start(2'd3, 12'h089, 12'h028, 4'd3, 12'h200);
    n_checks++; if (st_light_o !== 8'h01 || wt_light_o !== 8'h00) $display("FAIL ot_load got st=%h wt=%h want 01/00", st_light_o, wt_light_o); else n_pass++;
    @(negedge clk);
    fine = 12'h000; bal_in = 12'h000;
    n_checks++; if (wt_light_o !== 8'h07) $display("FAIL ot_wt1 got %h want 07", wt_light_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (wt_light_o !== 8'h03) $display("FAIL ot_wt2 got %h want 03", wt_light_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (wt_light_o !== 8'h01) $display("FAIL ot_wt3 got %h want 01", wt_light_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (st_light_o !== 8'h02 || wt_light_o !== 8'h00) $display("FAIL ot_cmp got st=%h wt=%h want 02/00", st_light_o, wt_light_o); else n_pass++;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (charge_o !== e.charge || bal_out_o !== e.bal || next_o !== e.paid)
      $display("FAIL ot_result got %h/%h/%b want %h/%h/%b", charge_o, bal_out_o, next_o, e.charge, e.bal, e.paid); else n_pass++;
    stop();
  endtask

  task automatic test_debt();
    sb.push_back({12'h123, 12'h100, 1'b0});
    sb.push_back({12'h123, 12'h007, 1'b1});
    start(2'd2, 12'h067, 12'h028, 4'd2, 12'h100);
    wait_settle(cyc, ok);
    n_checks++; if (!ok || cyc != 4 || st_light_o !== 8'h08) $display("FAIL debt_entry got cyc=%0d st=%h want 4/08", cyc, st_light_o); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (charge_o !== e.charge || bal_out_o !== e.bal || next_o !== e.paid)
      $display("FAIL debt_result got %h/%h/%b want %h/%h/%b", charge_o, bal_out_o, next_o, e.charge, e.bal, e.paid); else n_pass++;
    for (int j = 0; j < 12; j++) begin
      n_checks++; if (buzzer_o !== 1'((j / BUZZ_DIV) % 2)) $display("FAIL buzzer_%0d got %b want %b", j, buzzer_o, 1'((j / BUZZ_DIV) % 2)); else n_pass++;
      @(negedge clk);
    end
    get_digits(disp, ok);
    n_checks++; if (!ok || disp !== {8'h5E, seg(0), seg(2), seg(3)})
      $display("FAIL debt_display got %h want %h", disp, {8'h5E, seg(0), seg(2), seg(3)}); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    pulse(1'b0, 1'b0, 1'b1);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || st_light_o !== 8'h04 || bal_out_o !== e.bal || charge_o !== e.charge || next_o !== e.paid)
      $display("FAIL debt_paid got st=%h %h/%h/%b want 04 %h/%h/%b", st_light_o, charge_o, bal_out_o, next_o, e.charge, e.bal, e.paid); else n_pass++;
    n_checks++; if (buzzer_o !== 1'b0) $display("FAIL debt_buzzer_off got %b want 0", buzzer_o); else n_pass++;
    stop();
  endtask

  task automatic test_floor();
    sb.push_back({12'h123, 12'h100, 1'b0});
    sb.push_back({12'h123, 12'h100, 1'b0});
    sb.push_back({12'h123, 12'h110, 1'b0});
    start(2'd2, 12'h067, 12'h028, 4'd2, 12'h100);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || bal_out_o !== e.bal || st_light_o !== 8'h08) $display("FAIL floor_entry got %h st=%h want %h/08", bal_out_o, st_light_o, e.bal); else n_pass++;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    get_digits(disp, ok);
    n_checks++; if (!ok || disp !== {8'h5E, seg(0), seg(2), seg(3)})
      $display("FAIL floor_display got %h want %h", disp, {8'h5E, seg(0), seg(2), seg(3)}); else n_pass++;
    pulse(1'b0, 1'b0, 1'b1);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || bal_out_o !== e.bal || st_light_o !== 8'h08) $display("FAIL floor_recmp got %h st=%h want %h/08", bal_out_o, st_light_o, e.bal); else n_pass++;
    pulse(1'b1, 1'b0, 1'b1);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || bal_out_o !== e.bal || st_light_o !== 8'h08) $display("FAIL up_with_mid got %h st=%h want %h/08", bal_out_o, st_light_o, e.bal); else n_pass++;
    stop();
  endtask

  task automatic test_saturation();
    sb.push_back({12'h999, 12'h000, 1'b1});
    start(2'd3, 12'h089, 12'h200, 4'd15, 12'h999);
    @(negedge clk);
    n_checks++; if (wt_light_o !== 8'hFF) $display("FAIL sat_wt got %h want FF", wt_light_o); else n_pass++;
    wait_settle(cyc, ok);
    n_checks++; if (!ok || cyc + 1 != 11) $display("FAIL sat_latency got %0d want 11", cyc + 1); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (charge_o !== e.charge || bal_out_o !== e.bal || next_o !== e.paid)
      $display("FAIL sat_result got %h/%h/%b want %h/%h/%b", charge_o, bal_out_o, next_o, e.charge, e.bal, e.paid); else n_pass++;
    stop();
    sb.push_back({12'h093, 12'h106, 1'b1});
    start(2'd0, 12'h0A3, 12'h000, 4'd0, 12'h1FF);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || cyc != 2 || charge_o !== e.charge || bal_out_o !== e.bal)
      $display("FAIL clamp_result got cyc=%0d %h/%h want 2 %h/%h", cyc, charge_o, bal_out_o, e.charge, e.bal); else n_pass++;
    stop();
  endtask

  task automatic test_abort_reset();
    start(2'd3, 12'h089, 12'h028, 4'd3, 12'h200);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (st_light_o !== 8'h01 || wt_light_o !== 8'h03) $display("FAIL abort_mid_acc got st=%h wt=%h want 01/03", st_light_o, wt_light_o); else n_pass++;
    en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({charge_o, bal_out_o, next_o, buzzer_o, led_o, ena_o, st_light_o, wt_light_o} !== '0)
      $display("FAIL abort_outputs got st=%h wt=%h ena=%h led=%h want 0", st_light_o, wt_light_o, ena_o, led_o); else n_pass++;
    @(negedge clk);
    start(2'd2, 12'h067, 12'h028, 4'd2, 12'h100);
    wait_settle(cyc, ok);
    for (int j = 0; j < 5; j++) @(negedge clk);
    n_checks++; if (!ok || st_light_o !== 8'h08 || buzzer_o !== 1'b1) $display("FAIL prereset_debt got st=%h buz=%b want 08/1", st_light_o, buzzer_o); else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if ({charge_o, bal_out_o, next_o, buzzer_o, led_o, ena_o, st_light_o, wt_light_o} !== '0)
      $display("FAIL async_reset got %h/%h st=%h ena=%h led=%h buz=%b want 0", charge_o, bal_out_o, st_light_o, ena_o, led_o, buzzer_o); else n_pass++;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sb.push_back({12'h017, 12'h003, 1'b1});
    sb.push_back({12'h030, 12'h029, 1'b0});
    start(2'd1, 12'h012, 12'h005, 4'd1, 12'h020);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || cyc != 3 || charge_o !== e.charge || bal_out_o !== e.bal || next_o !== e.paid)
      $display("FAIL b2b_first got cyc=%0d %h/%h/%b want 3 %h/%h/%b", cyc, charge_o, bal_out_o, next_o, e.charge, e.bal, e.paid); else n_pass++;
    stop();
    start(2'd0, 12'h030, 12'h005, 4'd0, 12'h029);
    wait_settle(cyc, ok);
    e = sb.pop_front();
    n_checks++; if (!ok || cyc != 2 || st_light_o !== 8'h08 || charge_o !== e.charge || bal_out_o !== e.bal || next_o !== e.paid)
      $display("FAIL b2b_second got cyc=%0d st=%h %h/%h/%b want 2 08 %h/%h/%b", cyc, st_light_o, charge_o, bal_out_o, next_o, e.charge, e.bal, e.paid); else n_pass++;
    stop();
  endtask

  initial begin
    test_reset();
    test_simple_paid();
    test_overtime();
    test_debt();
    test_floor();
    test_saturation();
    test_abort_reset();
    test_back_to_back();
    n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bill_settle.md
# bill_settle

Settlement stage of the washing-machine controller, directly downstream of the wash stage. When enabled at the end of a wash, it computes the charge from the selected mode's price plus overtime fines, in 3-digit packed BCD. It then either deducts the charge from the balance or enters a debt loop, with buzzer and top-up buttons, until the balance covers it. It drives one 4-digit multiplexed 7-segment group, the state lights and the water lights, and raises `next` so the top level may advance to standby.

## Interface
- `SCAN_DIV`, 100000: clocks per digit-scan step.
- `BUZZ_DIV`, 25000000: clocks per buzzer half-period.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  stage enable, held high by the top level while the stage is active.
- `m_pos`, `u_pos`, `d_pos`  in  1 each  debounced single-cycle button pulses (mid, up, down).
- `mode`  in  2  wash mode: 0 dry, 1 small, 2 medium, 3 big.
- `bal_in`  in  12  balance, packed BCD {hundreds, tens, ones}.
- `dy_price`, `s_price`, `m_price`, `b_price`  in  12 each  per-mode prices, packed BCD.
- `fine`  in  12  fine per overtime unit, packed BCD.
- `ot_units`  in  4  overtime units reported by the wash stage, binary.
- `charge`  out  12  computed charge, BCD.
- `bal_out`  out  12  balance after settlement, BCD.
- `next`  out  1  settlement complete.
- `buzzer`  out  1  square-wave buzzer drive.
- `led`  out  8  segments {dp,g,f,e,d,c,b,a}, active-high; dp is always 0.
- `ena`  out  4  digit enables, one-hot, active-high; `ena[3]` is the leftmost digit.
- `st_light`  out  8  state lights.
- `wt_light`  out  8  water/overtime bar.

## Operation
- States are IDLE, LOAD, ACC, CMP, PAID and DEBT.
- **IDLE**
  - Entered whenever `en`=0, from any state, on the next edge.
  - All outputs are 0. Working registers are cleared.
- **LOAD** (first cycle with `en`=1)
  - `acc` ← price selected by `mode`.
  - `cnt` ← min(`ot_units`, 9).
  - `work` ← `bal_in`; `base` ← `bal_in`.
  - Any BCD digit >9 on any input is clamped to 9 as it is captured.
- **ACC**
  - While `cnt`≠0: `acc` ← BCD add of `acc` and `fine`, saturating at 999; `cnt`--.
  - One addition per cycle. Go to CMP when `cnt`=0, including when `cnt` is 0 on entry.
- **CMP** (1 cycle)
  - `charge` ← `acc`.
  - If `work` ≥ `acc`: `bal_out` ← `work` − `acc` (BCD subtract), then PAID.
  - Otherwise: `bal_out` ← `work`, then DEBT.
- **PAID**
  - `next`=1. Display shows 'P' followed by `bal_out`.
  - Buttons are ignored; the top level leaves on `m_pos`&`next`.
- **DEBT**
  - Display shows 'd' followed by the shortfall `acc` − `work`. `buzzer` toggles every `BUZZ_DIV` clocks.
  - `u_pos`: `work` += 010, saturating at 999.
  - `d_pos`: `work` −= 010, never below `base`; if the result would fall below `base`, `work` = `base`.
  - `m_pos`: go to CMP.
  - If `u_pos` and `d_pos` arrive in the same cycle, neither applies.
  - If `m_pos` coincides with `u_pos` or `d_pos`, the adjustment applies first, then CMP uses the updated `work`.
- **Display**
  - Digit 3 is a letter: 'P'=0x73, 'd'=0x5E, '-'=0x40 (LOAD/ACC/CMP).
  - Digits 2..0 are the value in standard encoding: 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F.
  - Leading zeros are shown.
- **`st_light`**
  - bit0 = LOAD or ACC; bit1 = CMP; bit2 = PAID; bit3 = DEBT; bits 7:4 = 0.
- **`wt_light`**
  - Thermometer of the remaining `cnt`, capped at 8: bits [k-1:0] set for k = min(`cnt`, 8).
  - 0 outside ACC.

## Timing
- Reset (async, `rst`=0):
  - State is IDLE; every output and counter is 0.
  - Reset may occur mid-ACC or in DEBT. No state survives it.
- Charge latency from the `en` rising edge: LOAD at cycle 0, ACC cycles 1..n (n = clamped `ot_units`), CMP at cycle n+1. `charge`, `bal_out` and `next` are valid at cycle n+2.
- Inputs are sampled only in LOAD, except the buttons and `en`. Changes afterwards are ignored until the stage is re-entered.
- Scan counter:
  - Free-runs while `en`=1. The active digit advances every `SCAN_DIV` clocks: 3→2→1→0→3.
  - Restarts at digit 3 in LOAD. `ena`=0000 in IDLE.
- Buzzer counter:
  - Runs only in DEBT. It is reset to 0 and `buzzer`=0 on leaving DEBT.
  - The first toggle occurs `BUZZ_DIV` clocks after DEBT entry.
- `next` drops in the same cycle `en` drops.

## Test plan
- **Simple paid:** `mode`=1, `s_price`=045, `ot_units`=0, `bal_in`=100 → at cycle 2: `charge`=045, `bal_out`=055, `next`=1, digits "P055".
- **Overtime:** `mode`=3, `b_price`=089, `fine`=028, `ot_units`=3, `bal_in`=200 → `charge`=173 at cycle 5, `bal_out`=027. `wt_light` reads 0x07, 0x03, 0x01 during ACC.
- **Debt loop:** `mode`=2, `m_price`=067, `fine`=028, `ot_units`=2, `bal_in`=100.
  - Expected on entry: DEBT, shortfall 023 shown, `buzzer` toggling with `BUZZ_DIV`=4.
  - Then 3×`u_pos`, then `m_pos` → PAID, `bal_out`=007, `buzzer`=0.
- **Floor and saturation:**
  - In DEBT, `d_pos` ×2 → `work` stays at `base`.
  - Separately, `ot_units`=15 with `fine`=200 and `b_price`=089 → `cnt` clamped to 9, `charge`=999.
- **Abort and reset:**
  - Drop `en` mid-ACC → IDLE next edge, all outputs 0.
  - Assert `rst` in DEBT → all outputs 0 immediately, asynchronously.
  - Re-enable with new inputs → fresh LOAD.
